// File: rtl/bank_cfg_pkg.sv
// Shared types and default constants for the bank configuration sequencer.
package bank_cfg_pkg;

    localparam int unsigned BL_WIDTH  = 160;
    localparam int unsigned WL_WIDTH  = 160;
    localparam int unsigned SETUP_CYC = 1;
    localparam int unsigned PULSE_CYC = 2;
    localparam int unsigned HOLD_CYC  = 1;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StSetup,
        StPulse,
        StHold
    } state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bank_cfg_wl_decoder.sv
// Combinational wordline decoder: one-hot strobe for addr when enabled, else all zero.
module bank_cfg_wl_decoder #(
    parameter int unsigned WL_WIDTH = bank_cfg_pkg::WL_WIDTH,
    localparam int unsigned AW = $clog2(WL_WIDTH)
) (
    input  logic                en,
    input  logic [AW-1:0]       addr,
    output logic [WL_WIDTH-1:0] wl
);

    always_comb begin
        wl = '0;
        for (int i = 0; i < WL_WIDTH; i++) begin
            wl[i] = en && (addr == AW'(i));
        end
    end

endmodule

// File: rtl/bank_cfg_sequencer.sv
// Streams bitline frames into a bank: per frame drives bl through setup/pulse/hold while
// strobing the addressed wordline during pulse.
module bank_cfg_sequencer #(
    parameter int unsigned BL_WIDTH  = bank_cfg_pkg::BL_WIDTH,
    parameter int unsigned WL_WIDTH  = bank_cfg_pkg::WL_WIDTH,
    parameter int unsigned SETUP_CYC = bank_cfg_pkg::SETUP_CYC,
    parameter int unsigned PULSE_CYC = bank_cfg_pkg::PULSE_CYC,
    parameter int unsigned HOLD_CYC  = bank_cfg_pkg::HOLD_CYC,
    localparam int unsigned AW = $clog2(WL_WIDTH)
) (
    input  logic                prog_clk,
    input  logic                prog_reset,
    input  logic                cfg_start,
    input  logic [AW:0]         cfg_num_wl,
    input  logic                cfg_abort,
    input  logic                frame_valid,
    output logic                frame_ready,
    input  logic [AW-1:0]       frame_addr,
    input  logic [BL_WIDTH-1:0] frame_bl,
    output logic [BL_WIDTH-1:0] bl,
    output logic [WL_WIDTH-1:0] wl,
    output logic                busy,
    output logic                done,
    output logic                err
);

    import bank_cfg_pkg::*;

    localparam int unsigned MAX_CYC = max3(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam int unsigned CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [AW:0] WL_LIMIT = (AW + 1)'(WL_WIDTH);

    state_e              state_q, state_d;
    logic [AW:0]         frames_q, frames_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [BL_WIDTH-1:0] bl_q, bl_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                accept;

    // Abort masks ready combinationally so an abort cycle never completes a handshake.
    assign frame_ready = (state_q == StFetch) && !cfg_abort;
    assign accept      = frame_valid && frame_ready;

    always_comb begin
        state_d  = state_q;
        frames_d = frames_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        bl_d     = bl_q;
        err_d    = err_q;
        done_d   = 1'b0;
        if (cfg_abort) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cfg_start) begin
                        if (cfg_num_wl != '0) begin
                            frames_d = cfg_num_wl;
                            err_d    = 1'b0;
                            state_d  = StFetch;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                StFetch: begin
                    if (accept) begin
                        if ({1'b0, frame_addr} < WL_LIMIT) begin
                            addr_d  = frame_addr;
                            bl_d    = frame_bl;
                            cnt_d   = CW'(SETUP_CYC - 1);
                            state_d = StSetup;
                        end else begin
                            err_d    = 1'b1;
                            frames_d = '0;
                            state_d  = StIdle;
                        end
                    end
                end
                StSetup: begin
                    if (cnt_q == '0) begin
                        cnt_d   = CW'(PULSE_CYC - 1);
                        state_d = StPulse;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                StPulse: begin
                    if (cnt_q == '0) begin
                        cnt_d   = CW'(HOLD_CYC - 1);
                        state_d = StHold;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                StHold: begin
                    if (cnt_q == '0) begin
                        frames_d = frames_q - (AW + 1)'(1);
                        if (frames_q == (AW + 1)'(1)) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StFetch;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q  <= StIdle;
            frames_q <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            bl_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            frames_q <= frames_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            bl_q     <= bl_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Outputs decode from state so reset clears bl/wl without waiting for an edge.
    assign bl   = (state_q inside {StSetup, StPulse, StHold}) ? bl_q : '0;
    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign err  = err_q;

    bank_cfg_wl_decoder #(
        .WL_WIDTH(WL_WIDTH)
    ) u_wl_decoder (
        .en  (state_q == StPulse),
        .addr(addr_q),
        .wl  (wl)
    );

endmodule

// File: tb/tb_bank_cfg_sequencer.sv
// Bench for bank_cfg_sequencer: directed vector table, hand-built corner sequences and a
// randomized run checked against a frame-timeline reference model.
module tb_bank_cfg_sequencer;

    localparam int BLW = 160;
    localparam int WLW = 160;
    localparam int S = 1;
    localparam int P = 2;
    localparam int H = 1;

    logic           clk;
    logic           prog_reset;
    logic           cfg_start;
    logic [8:0]     cfg_num_wl;
    logic           cfg_abort;
    logic           frame_valid;
    logic           frame_ready;
    logic [7:0]     frame_addr;
    logic [BLW-1:0] frame_bl;
    logic [BLW-1:0] bl;
    logic [WLW-1:0] wl;
    logic           busy;
    logic           done;
    logic           err;

    int checks = 0;
    int errors = 0;

    bank_cfg_sequencer dut (
        .prog_clk   (clk),
        .prog_reset (prog_reset),
        .cfg_start  (cfg_start),
        .cfg_num_wl (cfg_num_wl),
        .cfg_abort  (cfg_abort),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_addr (frame_addr),
        .frame_bl   (frame_bl),
        .bl         (bl),
        .wl         (wl),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [BLW-1:0] act, input logic [BLW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [WLW-1:0] onehot(input int a);
        logic [WLW-1:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        return v;
    endfunction

    task automatic drive(input bit st, input int num, input bit vld, input int addr, input bit ab);
        cfg_start   = st;
        cfg_num_wl  = 9'(num);
        frame_valid = vld;
        frame_addr  = 8'(addr);
        cfg_abort   = ab;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        prog_reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 prog_reset = 1'b0;
    endtask

    // Reference model: a run is a list of frames, each a timeline of S+P+H cycles after accept.
    bit             m_run, m_fetch, m_err, m_done;
    int             m_t, m_left, m_addr;
    logic [BLW-1:0] m_bl;

    task automatic model_update();
        m_done = 0;
        if (cfg_abort) begin
            m_run = 0;
        end else if (!m_run) begin
            if (cfg_start) begin
                if (cfg_num_wl > 0) begin
                    m_run = 1; m_fetch = 1; m_left = int'(cfg_num_wl); m_err = 0;
                end else begin
                    m_done = 1;
                end
            end
        end else if (m_fetch) begin
            if (frame_valid) begin
                if (frame_addr < WLW) begin
                    m_fetch = 0; m_t = 1; m_addr = int'(frame_addr); m_bl = frame_bl;
                end else begin
                    m_err = 1; m_run = 0;
                end
            end
        end else if (m_t == S + P + H) begin
            m_left--;
            if (m_left == 0) begin
                m_run = 0; m_done = 1;
            end else begin
                m_fetch = 1;
            end
        end else begin
            m_t++;
        end
    endtask

    typedef struct {
        bit st; int num; bit vld; int addr; bit ab;
        bit e_busy; bit e_ready; int e_wl; bit e_bl; bit e_done; bit e_err;
    } vec_t;

    vec_t tbl[18];
    int   acc_seen[$];
    int   saddr[3];
    int   sidx;
    logic [WLW-1:0] expw;
    logic [BLW-1:0] ones;

    initial begin
        ones = '1;
        frame_bl = ones;
        drive(0, 0, 0, 0, 0);
        prog_reset = 1'b1;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_ready", frame_ready, 0);
        chk("reset_bl", bl, 0);
        chk("reset_wl", wl, 0);
        @(posedge clk);
        @(posedge clk);
        #1 prog_reset = 1'b0;

        // st num vld addr ab | busy ready wl bl done err
        tbl[0]  = '{1, 1, 0,   0, 0, 0, 0, -1, 0, 0, 0};
        tbl[1]  = '{0, 0, 1,   5, 0, 1, 1, -1, 0, 0, 0};
        tbl[2]  = '{0, 0, 0,   0, 0, 1, 0, -1, 1, 0, 0};
        tbl[3]  = '{0, 0, 0,   0, 0, 1, 0,  5, 1, 0, 0};
        tbl[4]  = '{0, 0, 0,   0, 0, 1, 0,  5, 1, 0, 0};
        tbl[5]  = '{0, 0, 0,   0, 0, 1, 0, -1, 1, 0, 0};
        tbl[6]  = '{0, 0, 0,   0, 0, 0, 0, -1, 0, 1, 0};
        tbl[7]  = '{0, 0, 0,   0, 0, 0, 0, -1, 0, 0, 0};
        tbl[8]  = '{1, 2, 0,   0, 0, 0, 0, -1, 0, 0, 0};
        tbl[9]  = '{0, 0, 1, 160, 0, 1, 1, -1, 0, 0, 0};
        tbl[10] = '{0, 0, 0,   0, 0, 0, 0, -1, 0, 0, 1};
        tbl[11] = '{1, 1, 0,   0, 0, 0, 0, -1, 0, 0, 1};
        tbl[12] = '{0, 0, 0,   0, 0, 1, 1, -1, 0, 0, 0};
        tbl[13] = '{0, 0, 1,   3, 1, 1, 0, -1, 0, 0, 0};
        tbl[14] = '{0, 0, 0,   0, 0, 0, 0, -1, 0, 0, 0};
        tbl[15] = '{1, 0, 0,   0, 0, 0, 0, -1, 0, 0, 0};
        tbl[16] = '{0, 0, 0,   0, 0, 0, 0, -1, 0, 1, 0};
        tbl[17] = '{0, 0, 0,   0, 0, 0, 0, -1, 0, 0, 0};

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].st, tbl[i].num, tbl[i].vld, tbl[i].addr, tbl[i].ab);
            @(negedge clk);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("vec%0d_ready", i), frame_ready, tbl[i].e_ready);
            chk($sformatf("vec%0d_wl", i), wl, onehot(tbl[i].e_wl));
            chk($sformatf("vec%0d_bl", i), bl, tbl[i].e_bl ? ones : '0);
            chk($sformatf("vec%0d_done", i), done, tbl[i].e_done);
            chk($sformatf("vec%0d_err", i), err, tbl[i].e_err);
            next_cycle();
        end

        // Streaming run, valid held high; a stray start mid-run must be ignored.
        do_reset();
        saddr[0] = 0; saddr[1] = 159; saddr[2] = 7;
        sidx = 0;
        for (int c = 0; c < 20; c++) begin
            drive((c == 0) || (c == 8), (c == 0) ? 3 : 1, c >= 1, saddr[sidx], 0);
            @(negedge clk);
            expw = '0;
            for (int k = 0; k < 3; k++) begin
                if (c == 1 + 5 * k + 2 || c == 1 + 5 * k + 3) expw = onehot(saddr[k]);
            end
            chk($sformatf("stream_wl_c%0d", c), wl, expw);
            chk($sformatf("stream_done_c%0d", c), done, c == 16);
            chk($sformatf("stream_busy_c%0d", c), busy, (c >= 1) && (c <= 15));
            if (frame_ready && frame_valid) begin
                acc_seen.push_back(c);
                if (sidx < 2) sidx++;
            end
            next_cycle();
        end
        chk("stream_accepts", acc_seen.size(), 3);
        for (int k = 0; k < acc_seen.size() && k < 3; k++)
            chk($sformatf("stream_acc%0d", k), acc_seen[k], 1 + 5 * k);

        // Abort in first PULSE cycle.
        do_reset();
        drive(1, 1, 0, 0, 0); next_cycle();
        drive(0, 0, 1, 9, 0); next_cycle();
        drive(0, 0, 0, 0, 0); next_cycle();
        drive(0, 0, 0, 0, 1);
        @(negedge clk);
        chk("abort_pulse_wl", wl, onehot(9));
        next_cycle();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("abort_wl", wl, 0);
        chk("abort_bl", bl, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        next_cycle();
        @(negedge clk);
        chk("abort_done2", done, 0);
        next_cycle();
        drive(1, 1, 0, 0, 0); next_cycle();
        drive(0, 0, 1, 4, 0);
        @(negedge clk);
        chk("abort_restart_busy", busy, 1);
        chk("abort_restart_ready", frame_ready, 1);
        next_cycle();

        // Async reset in PULSE.
        do_reset();
        drive(1, 1, 0, 0, 0); next_cycle();
        drive(0, 0, 1, 20, 0); next_cycle();
        drive(0, 0, 0, 0, 0); next_cycle();
        @(negedge clk);
        chk("rst_pulse_wl", wl, onehot(20));
        #1 prog_reset = 1'b1;
        #1;
        chk("rst_async_wl", wl, 0);
        chk("rst_async_bl", bl, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_done", done, 0);
        chk("rst_async_err", err, 0);
        chk("rst_async_ready", frame_ready, 0);
        next_cycle();
        prog_reset = 1'b0;
        drive(0, 0, 1, 3, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("rst_idle_busy%0d", c), busy, 0);
            chk($sformatf("rst_idle_ready%0d", c), frame_ready, 0);
            next_cycle();
        end
        drive(1, 1, 1, 3, 0); next_cycle();
        @(negedge clk);
        chk("rst_restart_ready", frame_ready, 1);
        next_cycle();

        // Randomized run against the model.
        do_reset();
        m_run = 0; m_fetch = 0; m_err = 0; m_done = 0; m_t = 0; m_left = 0; m_addr = 0;
        m_bl = '0;
        for (int c = 0; c < 3000; c++) begin
            cfg_start   = ($urandom_range(0, 7) == 0);
            cfg_num_wl  = 9'($urandom_range(0, 4));
            cfg_abort   = ($urandom_range(0, 59) == 0);
            frame_valid = ($urandom_range(0, 3) != 0);
            frame_addr  = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(160, 255))
                                                       : 8'($urandom_range(0, 159));
            frame_bl    = {$urandom, $urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("rnd_busy", busy, m_run);
            chk("rnd_ready", frame_ready, m_run && m_fetch && !cfg_abort);
            chk("rnd_bl", bl, (m_run && !m_fetch) ? m_bl : '0);
            chk("rnd_wl", wl, (m_run && !m_fetch && m_t > S && m_t <= S + P) ? onehot(m_addr)
                                                                           : '0);
            chk("rnd_done", done, m_done);
            chk("rnd_err", err, m_err);
            @(posedge clk);
            model_update();
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bank_cfg_sequencer.md
BANK_CFG_SEQUENCER -- requirements
Module: bank_cfg_sequencer

Interface
REQ-001 SHALL have parameter BL_WIDTH, default 160, meaning bits per bitline frame.
REQ-002 SHALL have parameter WL_WIDTH, default 160, meaning number of wordlines in the bank.
REQ-003 SHALL have parameters SETUP_CYC, PULSE_CYC and HOLD_CYC, defaults 1, 2 and 1; each is a phase length in cycles and each SHALL be at least 1.
REQ-004 SHALL have the following ports, clock and reset first:
- prog_clk  input  1  configuration clock; one clock only.
- prog_reset  input  1  asynchronous, active-high reset.
- cfg_start  input  1  start a programming run.
- cfg_num_wl  input  AW+1  number of frames in the run, where AW = $clog2(WL_WIDTH).
- cfg_abort  input  1  synchronous abort.
- frame_valid  input  1  frame offered.
- frame_ready  output  1  sequencer accepts a frame.
- frame_addr  input  AW  target wordline index.
- frame_bl  input  BL_WIDTH  bitline data.
- bl  output  BL_WIDTH  bitline bus to the tiles.
- wl  output  WL_WIDTH  one-hot wordline strobe to the tiles.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse when a run completes.
- err  output  1  sticky address error flag.

Function
REQ-005 SHALL implement the states IDLE, FETCH, SETUP, PULSE and HOLD.
REQ-006 IDLE behaviour:
- cfg_start=1 with cfg_num_wl>0 SHALL load frames_left=cfg_num_wl, clear err, and go to FETCH.
- cfg_start=1 with cfg_num_wl=0 SHALL pulse done for one cycle and remain in IDLE.
REQ-007 cfg_start SHALL be ignored while busy=1.
REQ-008 busy SHALL be 1 in every state except IDLE.
REQ-009 frame_ready SHALL be 1 only in FETCH; a frame is accepted on a cycle where frame_valid=1 and frame_ready=1.
REQ-010 Frame accepted with frame_addr<WL_WIDTH:
- SHALL latch frame_addr and frame_bl.
- SHALL enter SETUP on the next cycle.
REQ-011 Frame accepted with frame_addr>=WL_WIDTH:
- SHALL set err=1.
- SHALL write nothing.
- SHALL return to IDLE with no done pulse.
REQ-012 bl SHALL equal the latched frame_bl in SETUP, PULSE and HOLD, and SHALL be 0 in IDLE and FETCH.
REQ-013 wl SHALL be 0 in every state except PULSE.
REQ-014 In PULSE, wl[addr] SHALL be 1 and all other wl bits SHALL be 0.
REQ-015 Phase timing, with the frame accepted at edge t:
- SETUP SHALL occupy cycles t+1 .. t+SETUP_CYC.
- PULSE SHALL occupy the next PULSE_CYC cycles.
- HOLD SHALL occupy the next HOLD_CYC cycles.
- These phases SHALL be timed by a single down-counter that reloads on each phase entry.
REQ-016 At the end of HOLD, frames_left SHALL decrement by 1.
REQ-017 After that decrement, if frames_left=0 the sequencer SHALL go to IDLE and pulse done on the first IDLE cycle; otherwise it SHALL go to FETCH.
REQ-018 Back-to-back frames SHALL be supported.
- With frame_valid held at 1, each frame SHALL take 1+SETUP_CYC+PULSE_CYC+HOLD_CYC cycles.
- With the default parameters that is 5 cycles per frame.
REQ-019 cfg_abort=1 in any state SHALL force the following next cycle:
- IDLE state, wl=0, bl=0.
- No done pulse; err unchanged.
- frame_ready=0 on that same cycle.
REQ-020 When cfg_abort and a frame handshake occur in the same cycle, abort SHALL take priority and the frame SHALL be dropped.
REQ-021 Duplicate addresses within a run SHALL be programmed again without error.
REQ-022 A frame stream that stalls in FETCH SHALL hold state indefinitely; there SHALL be no timeout.

Reset
REQ-023 prog_reset=1 SHALL asynchronously force the following:
- IDLE state.
- bl=0, wl=0.
- busy=0, done=0, err=0, frame_ready=0.
- frames_left=0, phase counter=0.
REQ-024 Reset asserted mid-PULSE SHALL drop wl to 0 without waiting for a clock edge.
REQ-025 After reset is released, the first run SHALL require a new cfg_start.

Structure
REQ-026 A shared package bank_cfg_pkg SHALL hold the state enum and the default constants BL_WIDTH, WL_WIDTH, SETUP_CYC, PULSE_CYC and HOLD_CYC.
REQ-027 The address-to-one-hot decode with an enable input SHALL be the sub-module bank_cfg_wl_decoder, parameterised by WL_WIDTH and combinational.
REQ-028 All registers SHALL be in the prog_clk domain; the sequencer SHALL contain no other sub-modules.

Verification
REQ-029 Single frame: cfg_num_wl=1, frame_addr=5, frame_bl=all ones.
- Required: bl=all ones for 4 cycles.
- Required: wl=1<<5 for exactly 2 cycles, beginning 2 cycles after the accept edge.
- Required: done pulses once, then busy=0.
REQ-030 Streaming run: cfg_num_wl=3, addresses 0, 159 and 7, frame_valid held at 1.
- Required: accepts 5 cycles apart.
- Required: three 2-cycle wl pulses at bits 0, 159 and 7.
- Required: done on cycle 16 after cfg_start.
REQ-031 Bad address: frame_addr=160 with WL_WIDTH=160.
- Required: err=1, no wl activity, return to IDLE, done=0.
- Required: a subsequent cfg_start clears err.
REQ-032 Abort mid-PULSE: cfg_abort in the first PULSE cycle.
- Required: next cycle wl=0, bl=0, busy=0, no done.
- Required: cfg_start is then accepted.
REQ-033 Async reset during PULSE: wl goes to 0 within the same cycle, all outputs read 0, and the FSM is in IDLE after release.
REQ-034 cfg_num_wl=0 pulses done for one cycle with busy never set; cfg_start while busy changes nothing.
